// File: rtl/replica_pkg.sv
// Shared types and sizing for the replica chain host I/O block.
package replica_pkg;

    localparam int CITY_NUM = 32;   // cities per ordering, beats per ordering transfer
    localparam int CITY_LOG = 5;    // bits per city index
    localparam int BASE_LOG = 3;    // replica base-id width
    localparam int DIS_W    = 27;   // total-distance width
    localparam int DIS_LAT  = 2;    // distance_shift to tail_dis_data valid
    localparam int HOST_W   = 32;   // host data width

    // Host command opcodes
    typedef enum logic [1:0] {
        OP_WR_ORD = 2'd0,
        OP_RD_ORD = 2'd1,
        OP_WR_DIS = 2'd2,
        OP_RD_DIS = 2'd3
    } io_op_t;

    // Read commands address ex_base_id_r, writes address ex_base_id_w
    function automatic logic op_is_read(input io_op_t op);
        return (op == OP_RD_ORD) || (op == OP_RD_DIS);
    endfunction

endpackage

// File: rtl/replica_host_io_fifo.sv
// Synchronous FIFO holding chain-tail beats until the host reads them.
// Depth CITY_NUM (a power of two, so the pointers wrap naturally).
module replica_host_io_fifo
    import replica_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [HOST_W-1:0]   wdata,
    input  logic                pop,
    output logic [HOST_W-1:0]   rdata,
    output logic                full,
    output logic                empty,
    output logic [CITY_LOG:0]   count
);

    localparam logic [CITY_LOG:0] DEPTH = (CITY_LOG+1)'(CITY_NUM);

    logic [HOST_W-1:0]   mem [CITY_NUM];
    logic [CITY_LOG-1:0] wr_ptr;
    logic [CITY_LOG-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write port
    // NOTE: the data array is deliberately not reset; count/pointers define validity,
    // and leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; push and pop in one cycle leave count unchanged
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/replica_host_io.sv
// Host-side end of the replica chain: turns host commands and write streams into
// chain-head ordering/distance writes, and queues chain-tail beats for the host.
module replica_host_io
    import replica_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [BASE_LOG-1:0] cmd_base,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [HOST_W-1:0]   s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [HOST_W-1:0]   m_data,
    output logic                busy,
    output logic                err,
    output logic                exchange_shift_d,
    output logic                distance_shift,
    output logic [BASE_LOG-1:0] ex_base_id_r,
    output logic [BASE_LOG-1:0] ex_base_id_w,
    output logic                head_ord_valid,
    output logic [CITY_LOG-1:0] head_ord_data,
    output logic [DIS_W-1:0]    head_dis_data,
    input  logic                tail_ord_valid,
    input  logic [CITY_LOG-1:0] tail_ord_data,
    input  logic [DIS_W-1:0]    tail_dis_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ORD, S_RD_ORD, S_WR_DIS, S_RD_DIS, S_DONE
    } state_t;

    localparam logic [CITY_LOG:0] FIFO_DEPTH = (CITY_LOG+1)'(CITY_NUM);
    localparam logic [CITY_LOG:0] CNT_LAST   = (CITY_LOG+1)'(CITY_NUM - 1);

    state_t              state, state_nx;
    logic [CITY_LOG:0]   cnt, cnt_nx;
    logic [DIS_LAT-1:0]  dly;          // distance_shift delay line for RD_DIS capture
    io_op_t              op_in;
    logic [CITY_LOG:0]   need;
    logic                cmd_fits;
    logic                cmd_fire;
    logic                s_fire;
    logic                fifo_push;
    logic [HOST_W-1:0]   fifo_wdata;
    logic [HOST_W-1:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CITY_LOG:0]   fifo_count;
    logic                unused_bits;

    assign op_in       = io_op_t'(cmd_op);
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign s_fire      = s_valid && s_ready;
    assign m_valid     = !fifo_empty;
    assign m_data      = fifo_empty ? '0 : fifo_rdata;
    assign busy        = (state != S_IDLE) || !fifo_empty;
    assign cmd_fits    = (FIFO_DEPTH - fifo_count) >= need;
    assign unused_bits = ^s_data[HOST_W-1:DIS_W];

    // FIFO space a command needs before it may start (reads only)
    always_comb begin
        need = '0;
        case (op_in)
            OP_RD_ORD: need = FIFO_DEPTH;
            OP_RD_DIS: need = (CITY_LOG+1)'(1);
            default:   need = '0;
        endcase
    end

    // Next state, beat counting, stream handshakes and FIFO pushes
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        cmd_ready  = 1'b0;
        s_ready    = 1'b0;
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        case (state)
            S_IDLE: begin
                cmd_ready = cmd_fits;
                if (cmd_valid && cmd_fits) begin
                    cnt_nx = '0;
                    case (op_in)
                        OP_WR_ORD: state_nx = S_WR_ORD;
                        OP_RD_ORD: state_nx = S_RD_ORD;
                        OP_WR_DIS: state_nx = S_WR_DIS;
                        default:   state_nx = S_RD_DIS;
                    endcase
                end
            end
            S_WR_ORD: begin
                s_ready = (cnt < FIFO_DEPTH);
                if (s_valid && s_ready) begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == CNT_LAST) state_nx = S_DONE;
                end
            end
            S_RD_ORD: begin
                if (tail_ord_valid) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = HOST_W'(tail_ord_data);
                    cnt_nx     = cnt + 1'b1;
                    if (cnt == CNT_LAST) state_nx = S_DONE;
                end
            end
            S_WR_DIS: begin
                s_ready = 1'b1;
                if (s_valid) state_nx = S_DONE;
            end
            S_RD_DIS: begin
                if (dly[DIS_LAT-1]) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = HOST_W'(tail_dis_data);
                    state_nx   = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, counter, chain-side registered outputs and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            dly              <= '0;
            exchange_shift_d <= 1'b0;
            distance_shift   <= 1'b0;
            ex_base_id_r     <= '0;
            ex_base_id_w     <= '0;
            head_ord_valid   <= 1'b0;
            head_ord_data    <= '0;
            head_dis_data    <= '0;
            err              <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            distance_shift <= 1'b0;
            head_ord_valid <= 1'b0;
            dly            <= {dly[DIS_LAT-2:0], distance_shift && (state == S_RD_DIS)};
            if ((tail_ord_valid && (state != S_RD_ORD)) || (fifo_push && fifo_full))
                err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (op_is_read(op_in)) ex_base_id_r <= cmd_base;
                        else                   ex_base_id_w <= cmd_base;
                        exchange_shift_d <= (op_in == OP_WR_ORD) || (op_in == OP_RD_ORD);
                        distance_shift   <= (op_in == OP_RD_DIS);
                    end
                end
                S_WR_ORD: begin
                    if (s_fire) begin
                        head_ord_valid <= 1'b1;
                        head_ord_data  <= s_data[CITY_LOG-1:0];
                    end
                end
                S_WR_DIS: begin
                    if (s_fire) begin
                        head_dis_data  <= s_data[DIS_W-1:0];
                        distance_shift <= 1'b1;
                    end
                end
                S_DONE:  exchange_shift_d <= 1'b0;
                default: ;
            endcase
        end
    end

    replica_host_io_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (m_valid && m_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
